// File: rtl/disp_pkg.sv
// Shared encodings for the LED matrix score display: modes, winner codes,
// checkerboard base and the banner blink bit.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_SPLASH = 2'd1,
    MODE_SCORE  = 2'd2,
    MODE_WIN    = 2'd3
  } mode_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Even rows show 1010... (MSB lit); sliced down to the matrix width.
  localparam logic [63:0] CHECKER_BASE = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int unsigned BLINK_BIT = 2;

endpackage

// File: rtl/matrix_scan_timer.sv
// Row multiplex timer: holds each row ROW_HOLD cycles, walks ROWS rows,
// flags the first cycle of a row and the last cycle of a frame.
module matrix_scan_timer #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned ROW_HOLD = 1000,
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] row_o,
  output logic             row_first_c,
  output logic             frame_done_c
);

  localparam int unsigned HOLD_W = $clog2(ROW_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              hold_last;

  always_comb begin
    hold_last = (hold_q == HOLD_W'(ROW_HOLD - 1));
    hold_d    = hold_q + HOLD_W'(1);
    row_d     = row_q;
    if (hold_last) begin
      hold_d = '0;
      row_d  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      row_q  <= '0;
    end else begin
      hold_q <= hold_d;
      row_q  <= row_d;
    end
  end

  assign row_o        = row_q;
  assign row_first_c  = (hold_q == '0);
  assign frame_done_c = hold_last && (row_q == ROW_W'(ROWS - 1));

endmodule

// File: rtl/led_matrix_score_display.sv
// LED matrix front end for the game: blank / splash / scoreboard / winner
// banner, with mode changes committed only at frame boundaries.
module led_matrix_score_display
  import disp_pkg::*;
#(
  parameter int unsigned ROWS          = 8,
  parameter int unsigned COLS          = 8,
  parameter int unsigned SCORE_W       = 3,
  parameter int unsigned ROW_HOLD      = 1000,
  parameter int unsigned SPLASH_FRAMES = 64,
  parameter int unsigned WIN_FRAMES    = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] sc1,
  input  logic [SCORE_W-1:0] sc2,
  input  logic [1:0]         winner,
  output logic [ROWS-1:0]    row_sel,
  output logic [COLS-1:0]    col_data,
  output logic               frame_done,
  output logic [1:0]         mode
);

  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned HALF       = COLS / 2;
  localparam int unsigned MAX_FRAMES = (SPLASH_FRAMES > WIN_FRAMES) ? SPLASH_FRAMES : WIN_FRAMES;
  localparam int unsigned FC_W       = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  logic [ROW_W-1:0] row;
  logic             row_first_c;
  logic             frame_done_c;

  matrix_scan_timer #(
    .ROWS     (ROWS),
    .ROW_HOLD (ROW_HOLD)
  ) u_scan (
    .clk          (clk),
    .reset        (reset),
    .row_o        (row),
    .row_first_c  (row_first_c),
    .frame_done_c (frame_done_c)
  );

  mode_e            mode_q, mode_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [1:0]       win_q, win_d;
  logic             start_q, start_pend_q, start_pend_d;
  logic [ROWS-1:0]  row_sel_q, row_sel_d;
  logic [COLS-1:0]  col_data_q, col_data_d;
  logic             frame_done_q;
  logic [COLS-1:0]  pattern_c;
  logic             blink_c;
  logic             p1_lit_c, p2_lit_c;

  // Column pattern for the current mode and row; scores are compared live.
  always_comb begin
    pattern_c = '0;
    blink_c   = ((32'(fc_q) >> BLINK_BIT) & 32'd1) != 32'd0;
    p1_lit_c  = 32'(row) < 32'(sc1);
    p2_lit_c  = 32'(row) < 32'(sc2);
    case (mode_q)
      MODE_SPLASH: pattern_c = CHECKER_BASE[COLS-1:0] ^ {COLS{row[0] ^ fc_q[0]}};
      MODE_SCORE:  pattern_c = {{HALF{p1_lit_c}}, {HALF{p2_lit_c}}};
      MODE_WIN: begin
        if (!blink_c) begin
          if (win_q == WIN_P1)      pattern_c = {{HALF{1'b1}}, {HALF{1'b0}}};
          else if (win_q == WIN_P2) pattern_c = {{HALF{1'b0}}, {HALF{1'b1}}};
        end
      end
      default:     pattern_c = '0;
    endcase
  end

  // Mode sequencing; every transition waits for the frame boundary.
  always_comb begin
    mode_d       = mode_q;
    fc_d         = fc_q;
    win_d        = win_q;
    start_pend_d = start_pend_q;
    if (start_i && !start_q && (mode_q == MODE_IDLE)) start_pend_d = 1'b1;
    if (frame_done_c) begin
      case (mode_q)
        MODE_IDLE: begin
          if (start_pend_q) begin
            mode_d       = MODE_SPLASH;
            start_pend_d = 1'b0;
            fc_d         = '0;
          end
        end
        MODE_SPLASH: begin
          if (fc_q == FC_W'(SPLASH_FRAMES - 1)) begin
            mode_d = MODE_SCORE;
            fc_d   = '0;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
        MODE_SCORE: begin
          if ((winner == WIN_P1) || (winner == WIN_P2)) begin
            mode_d = MODE_WIN;
            win_d  = winner;
            fc_d   = '0;
          end
        end
        MODE_WIN: begin
          if (fc_q == FC_W'(WIN_FRAMES - 1)) begin
            mode_d = MODE_IDLE;
            fc_d   = '0;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
        default: mode_d = MODE_IDLE;
      endcase
    end
    row_sel_d  = ROWS'(1) << row;
    col_data_d = row_first_c ? '0 : pattern_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_IDLE;
      fc_q         <= '0;
      win_q        <= WIN_NONE;
      start_q      <= 1'b0;
      start_pend_q <= 1'b0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      fc_q         <= fc_d;
      win_q        <= win_d;
      start_q      <= start_i;
      start_pend_q <= start_pend_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_c;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_done = frame_done_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_led_matrix_score_display.sv
// Self-checking bench for led_matrix_score_display: cycle-stepped reference
// model built from frame arithmetic, randomized and directed scenarios.
module tb_led_matrix_score_display;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int SCORE_W  = 4;
  localparam int ROW_HOLD = 4;
  localparam int SPLASH_F = 2;
  localparam int WIN_F    = 4;
  localparam int FRAME    = ROWS * ROW_HOLD;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start_i = 1'b0;
  logic [SCORE_W-1:0] sc1 = '0;
  logic [SCORE_W-1:0] sc2 = '0;
  logic [1:0]         winner = 2'd0;
  logic [ROWS-1:0]    row_sel;
  logic [COLS-1:0]    col_data;
  logic               frame_done;
  logic [1:0]         mode;

  led_matrix_score_display #(
    .ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W), .ROW_HOLD(ROW_HOLD),
    .SPLASH_FRAMES(SPLASH_F), .WIN_FRAMES(WIN_F)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .sc1(sc1), .sc2(sc2),
    .winner(winner), .row_sel(row_sel), .col_data(col_data),
    .frame_done(frame_done), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since reset, current mode, frames in mode.
  int m_cnt, m_mode, m_fc, m_win;
  bit m_pend, m_prev_start;
  logic [ROWS-1:0] exp_row_sel;
  logic [COLS-1:0] exp_col;
  logic            exp_fd;
  logic [1:0]      exp_mode;

  function automatic logic [COLS-1:0] exp_pattern(int md, int r, int fc, int s1, int s2, int w);
    logic [COLS-1:0] p = '0;
    for (int i = 0; i < COLS; i++) begin
      bit left = (i >= COLS / 2);
      case (md)
        1: p[i] = (((i % 2) == 1) != ((r % 2) == 1)) != ((fc % 2) == 1);
        2: p[i] = left ? (r < s1) : (r < s2);
        3: p[i] = (((fc / 4) % 2) == 0) && ((w == 1 && left) || (w == 2 && !left));
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_fc = 0; m_win = 0; m_pend = 0; m_prev_start = 0;
  endtask

  task automatic model_step();
    int  row  = (m_cnt / ROW_HOLD) % ROWS;
    int  hold = m_cnt % ROW_HOLD;
    bit  fd   = (m_cnt % FRAME) == FRAME - 1;
    bit  edge_s = start_i && !m_prev_start;
    bit  new_pend = m_pend;
    exp_row_sel = ROWS'(1) << row;
    exp_col     = (hold == 0) ? '0 : exp_pattern(m_mode, row, m_fc, int'(sc1), int'(sc2), m_win);
    exp_fd      = fd;
    if (edge_s && m_mode == 0) new_pend = 1;
    if (fd) begin
      case (m_mode)
        0: if (m_pend) begin m_mode = 1; new_pend = 0; m_fc = 0; end
        1: if (m_fc == SPLASH_F - 1) begin m_mode = 2; m_fc = 0; end else m_fc++;
        2: if (winner == 2'd1 || winner == 2'd2) begin m_mode = 3; m_win = int'(winner); m_fc = 0; end
        default: if (m_fc == WIN_F - 1) begin m_mode = 0; m_fc = 0; end else m_fc++;
      endcase
    end
    m_pend = new_pend;
    m_prev_start = start_i;
    m_cnt++;
    exp_mode = 2'(m_mode);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({row_sel, col_data, frame_done, mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got row_sel=%h col=%h fd=%b mode=%0d required all 0",
               row_sel, col_data, frame_done, mode);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_scan();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL idle_scan cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
    end
  endtask

  task automatic test_splash();
    for (int c = 0; c < 4 * FRAME + 8; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL splash cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
      if (c == 10) start_i = 1'b1;
      if (c == 60) start_i = 1'b0;
    end
  endtask

  task automatic test_score();
    sc1 = 4'd3; sc2 = 4'd5;
    for (int c = 0; c < 4 * FRAME; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL score cyc=%0d sc=%0d/%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c, sc1, sc2,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
      if (c == FRAME - 1)     begin sc1 = 4'd15; sc2 = 4'd8; end
      if (c == 2 * FRAME - 1) winner = 2'd3;
      if (c >= 2 * FRAME)     begin sc1 = SCORE_W'($urandom); sc2 = SCORE_W'($urandom); end
    end
    winner = 2'd0;
  endtask

  task automatic test_win();
    for (int c = 0; c < 7 * FRAME; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL win cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
      if (c == 10) winner = 2'd2;
      if (c == 15) winner = 2'd0;
      if (c == 50 || c == 100) start_i = 1'b1;
      if (c == 54 || c == 104) start_i = 1'b0;
      sc1 = SCORE_W'($urandom); sc2 = SCORE_W'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    start_i = 1'b1;
    for (int c = 0; c < 12 * FRAME && !reached; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL reset_mid_run cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
      if (c == 3) start_i = 1'b0;
      winner = (m_mode == 2) ? 2'd1 : 2'd0;
      if (m_mode == 3 && m_fc == 0 && (((m_cnt - 1) / ROW_HOLD) % ROWS) == 5) reached = 1;
    end
    winner = 2'd0;
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reset_mid_reach got not-reached required WIN row 5 within budget");
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({row_sel, col_data, frame_done, mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got %h/%h/%b/%0d required all 0", row_sel, col_data, frame_done, mode);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL reset_mid_restart cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40 * FRAME; c++) begin
      tick();
      n_checks++;
      if ({row_sel, col_data, frame_done, mode} !== {exp_row_sel, exp_col, exp_fd, exp_mode}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", c,
                 row_sel, col_data, frame_done, mode, exp_row_sel, exp_col, exp_fd, exp_mode);
      end
      if ($urandom_range(0, 29) == 0) start_i = ~start_i;
      if ($urandom_range(0, 49) == 0) winner = 2'($urandom);
      else if ($urandom_range(0, 9) == 0) winner = 2'd0;
      sc1 = SCORE_W'($urandom);
      sc2 = SCORE_W'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_splash();
    test_score();
    test_win();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
